hub75_bcm_scan: RTL and testbench



---
 rtl/hub75_bcm_scan.sv | 229 ++++++++++++++++++++++
 tb/tb_hub75_bcm_scan.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_bcm_scan.sv
// HUB75 scan engine: walks row pairs and bit planes, shifts pixel pairs out on
// hub75_clk, latches, then holds OE low for a binary-weighted time (BCM).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | panel blanked, waiting for enable_in at a frame boundary
// PREFETCH | issue read of column 0 for the current row pair
// SHIFT    | two phases per column: ph0 capture data, ph1 clock high
// BLANK    | load the panel row address while still blanked
// LATCH    | one-cycle latch strobe
// DISPLAY  | OE low for OE_BASE<<plane cycles (down-counter)
module hub75_bcm_scan #(
   parameter int NUM_COLS    = 64,
   parameter int SCAN_RATE   = 32,
   parameter int COLOR_DEPTH = 3,
   parameter int OE_BASE     = 8
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         enable_in,
   output logic                         pix_rd_out,
   output logic [$clog2(SCAN_RATE)-1:0] pix_row_out,
   output logic [$clog2(NUM_COLS)-1:0]  pix_col_out,
   input  logic [3*COLOR_DEPTH-1:0]     pix_data0_in,
   input  logic [3*COLOR_DEPTH-1:0]     pix_data1_in,
   output logic [$clog2(SCAN_RATE)-1:0] hub75_addr,
   output logic [2:0]                   hub75_rgb0,
   output logic [2:0]                   hub75_rgb1,
   output logic                         hub75_clk,
   output logic                         hub75_latch,
   output logic                         hub75_OE,
   output logic                         busy_out,
   output logic                         frame_done_out
);

   localparam int RW = $clog2(SCAN_RATE);
   localparam int CW = $clog2(NUM_COLS);
   localparam int PW = (COLOR_DEPTH > 1) ? $clog2(COLOR_DEPTH) : 1;
   localparam int DW = COLOR_DEPTH - 1 + $clog2(OE_BASE + 1);

   localparam logic [CW-1:0] COL_LAST   = CW'(NUM_COLS - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(SCAN_RATE - 1);
   localparam logic [PW-1:0] PLANE_LAST = PW'(COLOR_DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREFETCH,
      S_SHIFT,
      S_BLANK,
      S_LATCH,
      S_DISPLAY
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [RW-1:0]   r_row, w_row_nxt;
   logic [PW-1:0]   r_plane, w_plane_nxt;
   logic [CW-1:0]   r_col, w_col_nxt;
   logic            r_ph, w_ph_nxt;
   logic [DW-1:0]   r_cnt, w_cnt_nxt;
   logic            r_rd, w_rd_nxt;
   logic [RW-1:0]   r_prow, w_prow_nxt;
   logic [CW-1:0]   r_pcol, w_pcol_nxt;
   logic [RW-1:0]   r_addr, w_addr_nxt;
   logic [2:0]      r_rgb0, w_rgb0_nxt;
   logic [2:0]      r_rgb1, w_rgb1_nxt;
   logic            r_clk, w_clk_nxt;
   logic            r_latch, w_latch_nxt;
   logic            r_oe, w_oe_nxt;
   logic            r_busy, w_busy_nxt;
   logic            r_fd, w_fd_nxt;

   logic [COLOR_DEPTH-1:0] w_r0, w_g0, w_b0, w_r1, w_g1, w_b1;
   logic [DW-1:0]          w_cnt_load;

   assign w_r0 = pix_data0_in[3*COLOR_DEPTH-1 -: COLOR_DEPTH];
   assign w_g0 = pix_data0_in[2*COLOR_DEPTH-1 -: COLOR_DEPTH];
   assign w_b0 = pix_data0_in[COLOR_DEPTH-1:0];
   assign w_r1 = pix_data1_in[3*COLOR_DEPTH-1 -: COLOR_DEPTH];
   assign w_g1 = pix_data1_in[2*COLOR_DEPTH-1 -: COLOR_DEPTH];
   assign w_b1 = pix_data1_in[COLOR_DEPTH-1:0];

   assign w_cnt_load = (DW'(OE_BASE) << r_plane) - 1'b1;

   always_comb begin
      w_state_nxt = r_state;
      w_row_nxt   = r_row;
      w_plane_nxt = r_plane;
      w_col_nxt   = r_col;
      w_ph_nxt    = r_ph;
      w_cnt_nxt   = r_cnt;
      w_rd_nxt    = 1'b0;
      w_prow_nxt  = r_prow;
      w_pcol_nxt  = r_pcol;
      w_addr_nxt  = r_addr;
      w_rgb0_nxt  = r_rgb0;
      w_rgb1_nxt  = r_rgb1;
      w_clk_nxt   = 1'b0;
      w_latch_nxt = 1'b0;
      w_oe_nxt    = 1'b1;
      w_fd_nxt    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (enable_in) begin
               w_state_nxt = S_PREFETCH;
               w_row_nxt   = '0;
               w_plane_nxt = '0;
               w_rd_nxt    = 1'b1;
               w_prow_nxt  = '0;
               w_pcol_nxt  = '0;
            end
         end
         S_PREFETCH: begin
            w_state_nxt = S_SHIFT;
            w_col_nxt   = '0;
            w_ph_nxt    = 1'b0;
         end
         S_SHIFT: begin
            if (!r_ph) begin
               // data for r_col is on the bus now; it is presented with the rising edge
               w_rgb0_nxt = {w_r0[r_plane], w_g0[r_plane], w_b0[r_plane]};
               w_rgb1_nxt = {w_r1[r_plane], w_g1[r_plane], w_b1[r_plane]};
               w_ph_nxt   = 1'b1;
               w_clk_nxt  = 1'b1;
               if (r_col != COL_LAST) begin
                  w_rd_nxt   = 1'b1;
                  w_pcol_nxt = r_col + 1'b1;
               end
            end else if (r_col == COL_LAST) begin
               w_state_nxt = S_BLANK;
               w_addr_nxt  = r_row;
            end else begin
               w_col_nxt = r_col + 1'b1;
               w_ph_nxt  = 1'b0;
            end
         end
         S_BLANK: begin
            w_state_nxt = S_LATCH;
            w_latch_nxt = 1'b1;
         end
         S_LATCH: begin
            w_state_nxt = S_DISPLAY;
            w_oe_nxt    = 1'b0;
            w_cnt_nxt   = w_cnt_load;
         end
         S_DISPLAY: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 1'b1;
               w_oe_nxt  = 1'b0;
            end else begin
               w_state_nxt = S_PREFETCH;
               w_rd_nxt    = 1'b1;
               w_pcol_nxt  = '0;
               if (r_plane != PLANE_LAST) begin
                  w_plane_nxt = r_plane + 1'b1;
                  w_prow_nxt  = r_row;
               end else if (r_row != ROW_LAST) begin
                  w_plane_nxt = '0;
                  w_row_nxt   = r_row + 1'b1;
                  w_prow_nxt  = r_row + 1'b1;
               end else begin
                  w_plane_nxt = '0;
                  w_row_nxt   = '0;
                  w_prow_nxt  = '0;
                  w_fd_nxt    = 1'b1;
                  if (!enable_in) begin
                     w_state_nxt = S_IDLE;
                     w_rd_nxt    = 1'b0;
                  end
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state <= S_IDLE;
         r_row   <= '0;
         r_plane <= '0;
         r_col   <= '0;
         r_ph    <= 1'b0;
         r_cnt   <= '0;
         r_rd    <= 1'b0;
         r_prow  <= '0;
         r_pcol  <= '0;
         r_addr  <= '0;
         r_rgb0  <= '0;
         r_rgb1  <= '0;
         r_clk   <= 1'b0;
         r_latch <= 1'b0;
         r_oe    <= 1'b1;
         r_busy  <= 1'b0;
         r_fd    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_row   <= w_row_nxt;
         r_plane <= w_plane_nxt;
         r_col   <= w_col_nxt;
         r_ph    <= w_ph_nxt;
         r_cnt   <= w_cnt_nxt;
         r_rd    <= w_rd_nxt;
         r_prow  <= w_prow_nxt;
         r_pcol  <= w_pcol_nxt;
         r_addr  <= w_addr_nxt;
         r_rgb0  <= w_rgb0_nxt;
         r_rgb1  <= w_rgb1_nxt;
         r_clk   <= w_clk_nxt;
         r_latch <= w_latch_nxt;
         r_oe    <= w_oe_nxt;
         r_busy  <= w_busy_nxt;
         r_fd    <= w_fd_nxt;
      end
   end

   assign pix_rd_out     = r_rd;
   assign pix_row_out    = r_prow;
   assign pix_col_out    = r_pcol;
   assign hub75_addr     = r_addr;
   assign hub75_rgb0     = r_rgb0;
   assign hub75_rgb1     = r_rgb1;
   assign hub75_clk      = r_clk;
   assign hub75_latch    = r_latch;
   assign hub75_OE       = r_oe;
   assign busy_out       = r_busy;
   assign frame_done_out = r_fd;

endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Bench for hub75_bcm_scan: stimulus pushes expected shift data, latch
// addresses, OE run lengths and frame periods; a negedge monitor checks them.
module tb_hub75_bcm_scan;
   localparam int NC = 4, SR = 2, CD = 2, OB = 2;
   localparam int FRAME = 56;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic       enable_in = 1'b0;
   logic [5:0] pix_data0_in, pix_data1_in;
   logic       pix_rd_out;
   logic [0:0] pix_row_out;
   logic [1:0] pix_col_out;
   logic [0:0] hub75_addr;
   logic [2:0] hub75_rgb0, hub75_rgb1;
   logic       hub75_clk, hub75_latch, hub75_OE, busy_out, frame_done_out;

   hub75_bcm_scan #(.NUM_COLS(NC), .SCAN_RATE(SR), .COLOR_DEPTH(CD), .OE_BASE(OB)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
      .pix_rd_out(pix_rd_out), .pix_row_out(pix_row_out), .pix_col_out(pix_col_out),
      .pix_data0_in(pix_data0_in), .pix_data1_in(pix_data1_in),
      .hub75_addr(hub75_addr), .hub75_rgb0(hub75_rgb0), .hub75_rgb1(hub75_rgb1),
      .hub75_clk(hub75_clk), .hub75_latch(hub75_latch), .hub75_OE(hub75_OE),
      .busy_out(busy_out), .frame_done_out(frame_done_out)
   );

   always #5 clk_in = ~clk_in;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge clk_in) cyc = cyc + 1;

   logic [5:0] q_rgb[$];
   int         q_addr[$];
   int         q_oe[$];
   int         q_fd[$];

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // expected {rgb0,rgb1} for source pattern d0={c,r,~r,~c}, d1={~c,~r,r,c}
   function automatic logic [5:0] exp_rgb(input int r, input int b, input int c);
      logic [1:0] cc;
      logic       rr, cb, g;
      cc = 2'(c);
      rr = 1'(r);
      cb = cc[b[0]];
      g  = b[0] ? rr : ~rr;
      return {cb, g, ~cb, ~cb, ~g, cb};
   endfunction

   task automatic push_frame();
      for (int r = 0; r < SR; r++)
         for (int b = 0; b < CD; b++) begin
            for (int c = 0; c < NC; c++) q_rgb.push_back(exp_rgb(r, b, c));
            q_addr.push_back(r);
            q_oe.push_back(OB << b);
         end
      q_fd.push_back(FRAME);
   endtask

   // pixel source: 1-cycle read latency, junk when no read was issued
   logic       rd_p = 1'b0, rr_p = 1'b0;
   logic [1:0] cc_p = 2'b00;
   logic       cap_first = 1'b0, got_first = 1'b0;
   int         first_row = -1, first_col = -1;
   initial begin
      pix_data0_in = 6'b101101;
      pix_data1_in = 6'b010010;
      forever begin
         @(negedge clk_in);
         if (rd_p) begin
            pix_data0_in = {cc_p, rr_p, ~rr_p, ~cc_p};
            pix_data1_in = {~cc_p, ~rr_p, rr_p, cc_p};
         end else begin
            pix_data0_in = 6'b101101;
            pix_data1_in = 6'b010010;
         end
         rd_p = pix_rd_out;
         rr_p = pix_row_out;
         cc_p = pix_col_out;
         if (cap_first && pix_rd_out) begin
            first_row = int'(pix_row_out);
            first_col = int'(pix_col_out);
            got_first = 1'b1;
            cap_first = 1'b0;
         end
      end
   end

   // monitor
   logic       p_clk = 1'b0, p_oe = 1'b1, p_busy = 1'b0;
   logic [0:0] p_addr = 1'b0;
   logic [5:0] p_rgb = 6'd0;
   int run = 0, rises = 0, lats = 0, fstart = 0, frames = 0;
   initial begin
      forever begin
         @(negedge clk_in);
         if (rst_in) begin
            run = 0; rises = 0; lats = 0;
         end else begin
            if (hub75_clk && !p_clk) begin
               check("clk_rise_while_blanked", int'(hub75_OE), 1);
               if (q_rgb.size() == 0) check("rgb_unexpected_rise", 1, 0);
               else check("rgb_plane_bits", int'({hub75_rgb0, hub75_rgb1}), int'(q_rgb.pop_front()));
               rises++;
            end
            if ({hub75_rgb0, hub75_rgb1} != p_rgb) check("rgb_change_clk_low", int'(p_clk), 0);
            if (hub75_addr != p_addr) begin
               check("addr_change_oe_high", int'({p_oe, hub75_OE}), 3);
               check("addr_change_before_latch", int'(hub75_latch), 0);
            end
            if (hub75_latch) begin
               lats++;
               check("latch_oe_high", int'(hub75_OE), 1);
               check("addr_setup_before_latch", int'(p_addr), int'(hub75_addr));
               if (q_addr.size() == 0) check("latch_unexpected", 1, 0);
               else check("latch_addr", int'(hub75_addr), q_addr.pop_front());
            end
            if (!hub75_OE) run++;
            else if (!p_oe && run > 0) begin
               if (q_oe.size() == 0) check("oe_unexpected", 1, 0);
               else check("oe_low_cycles", run, q_oe.pop_front());
               run = 0;
            end
            if (frame_done_out) begin
               if (q_fd.size() == 0) check("frame_done_unexpected", 1, 0);
               else check("frame_period", cyc - fstart, q_fd.pop_front());
               check("clk_rises_per_frame", rises, NC * CD * SR);
               check("latches_per_frame", lats, CD * SR);
               rises = 0; lats = 0;
               fstart = cyc;
               frames++;
            end else if (busy_out && !p_busy) begin
               fstart = cyc;
            end
         end
         p_clk = hub75_clk; p_oe = hub75_OE; p_busy = busy_out;
         p_addr = hub75_addr; p_rgb = {hub75_rgb0, hub75_rgb1};
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic wait_frames(input int target, input int budget);
      int n;
      n = 0;
      while (frames < target && n < budget) begin
         @(posedge clk_in);
         n++;
      end
      #1;
      check("frames_completed", frames, target);
   endtask

   task automatic pulse_enable();
      enable_in = 1'b1;
      tick(1);
      enable_in = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, int'(busy_out), 0);
      check({tag, "_oe"}, int'(hub75_OE), 1);
      check({tag, "_clk"}, int'(hub75_clk), 0);
      check({tag, "_latch"}, int'(hub75_latch), 0);
   endtask

   initial begin
      int n;
      // reset values
      rst_in = 1'b1;
      tick(3);
      check_idle("reset");
      check("reset_rd", int'(pix_rd_out), 0);
      check("reset_row", int'(pix_row_out), 0);
      check("reset_col", int'(pix_col_out), 0);
      check("reset_addr", int'(hub75_addr), 0);
      check("reset_rgb0", int'(hub75_rgb0), 0);
      check("reset_rgb1", int'(hub75_rgb1), 0);
      check("reset_frame_done", int'(frame_done_out), 0);
      rst_in = 1'b0;
      tick(2);

      // single frame from a one-cycle enable pulse
      push_frame();
      pulse_enable();
      wait_frames(1, 150);
      tick(3);
      check_idle("single_end");
      check("single_rgb_drained", q_rgb.size(), 0);
      check("single_oe_drained", q_oe.size(), 0);

      // continuous frames, enable dropped mid third frame
      push_frame(); push_frame(); push_frame();
      enable_in = 1'b1;
      wait_frames(3, 250);
      tick(20);
      enable_in = 1'b0;
      wait_frames(4, 150);
      tick(3);
      check_idle("cont_end");
      check("cont_fd_drained", q_fd.size(), 0);

      // reset while OE is active
      push_frame();
      pulse_enable();
      n = 0;
      while (hub75_OE && n < 100) begin
         tick(1);
         n++;
      end
      check("reached_display", int'(hub75_OE), 0);
      rst_in = 1'b1;
      tick(1);
      check_idle("midreset");
      check("midreset_rd", int'(pix_rd_out), 0);
      q_rgb.delete(); q_addr.delete(); q_oe.delete(); q_fd.delete();
      tick(2);
      rst_in = 1'b0;
      tick(1);
      cap_first = 1'b1;
      push_frame();
      pulse_enable();
      wait_frames(5, 150);
      check("restart_read_seen", int'(got_first), 1);
      check("restart_first_row", first_row, 0);
      check("restart_first_col", first_col, 0);
      tick(3);
      check_idle("final");
      check("final_rgb_drained", q_rgb.size(), 0);
      check("final_addr_drained", q_addr.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
